// File: rtl/window_buffer.sv
// window_buffer: builds the OPE_SIZE x OPE_SIZE pixel window from a raster
// pixel stream. Line buffers hold the previous OPE_SIZE-1 rows and a register
// window slides one column per accepted pixel.
// Ports:
//   clk        clock, all state on posedge
//   rst        asynchronous active-low reset
//   reflesh    synchronous frame restart (same clear as reset)
//   in         [8] pixel valid strobe, [7:0] pixel
//   d          window, tap(i,j) at [9*(i*OPE_SIZE+j) +: 9], [8] = window valid
//   frame_done 1-cycle pulse with the last window of a frame
module window_buffer #(
    parameter int OPE_SIZE   = 3,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           reflesh,
    input  logic [8:0]                     in,
    output logic [9*OPE_SIZE*OPE_SIZE-1:0] d,
    output logic                           frame_done
);

    localparam int N  = OPE_SIZE;
    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
    localparam logic [XW-1:0] X_MIN  = XW'(N - 1);
    localparam logic [YW-1:0] Y_MIN  = YW'(N - 1);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          accept;
    logic          x_end;
    logic          y_end;
    logic          in_win;

    // line_ram[0] holds row y-1, line_ram[k] holds row y-1-k
    logic [7:0] line_ram [N-1][IMG_WIDTH];
    logic [7:0] rd_q     [N-1];
    logic [7:0] pix_q;

    logic acc_q;
    logic val_q;
    logic last_q;
    logic val_w;

    logic [7:0] win [N][N];

    assign accept = in[8] & ~reflesh;
    assign x_end  = (x == X_LAST);
    assign y_end  = (y == Y_LAST);
    assign in_win = (x >= X_MIN) && (y >= Y_MIN);

    // Line buffers: read-before-write at address x; each row cascades into
    // the next-older buffer so the column shifts down one row per frame line.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < N - 1; k++) begin
                rd_q[k] <= line_ram[k][x];
            end
            line_ram[0][x] <= in[7:0];
            for (int k = 1; k < N - 1; k++) begin
                line_ram[k][x] <= line_ram[k-1][x];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x          <= '0;
            y          <= '0;
            pix_q      <= '0;
            acc_q      <= 1'b0;
            val_q      <= 1'b0;
            last_q     <= 1'b0;
            val_w      <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else if (reflesh) begin
            x          <= '0;
            y          <= '0;
            pix_q      <= '0;
            acc_q      <= 1'b0;
            val_q      <= 1'b0;
            last_q     <= 1'b0;
            val_w      <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else begin
            acc_q      <= accept;
            val_q      <= accept & in_win;
            last_q     <= accept & in_win & x_end & y_end;
            val_w      <= val_q;
            frame_done <= last_q;

            if (accept) begin
                pix_q <= in[7:0];
                if (x_end) begin
                    x <= '0;
                    y <= y_end ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end

            // Shift on the cycle after acceptance; idle cycles freeze it.
            if (acc_q) begin
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N - 1; j++) begin
                        win[i][j] <= win[i][j+1];
                    end
                end
                for (int i = 0; i < N - 1; i++) begin
                    win[i][N-1] <= rd_q[N-2-i];
                end
                win[N-1][N-1] <= pix_q;
            end
        end
    end

    always_comb begin
        d = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                d[9*(i*N+j) +: 9] = {val_w, win[i][j]};
            end
        end
    end

endmodule

// File: tb/tb_window_buffer.sv
// tb_window_buffer: randomized stimulus against a frame-image reference
// model for window_buffer (8x6 image, 3x3 window).
`timescale 1ns/1ps
module tb_window_buffer;

    localparam int N  = 3;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 9 * N * N;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          reflesh = 1'b0;
    logic [8:0]    in      = 9'h0;
    logic [DW-1:0] d;
    logic          frame_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int vbad  = 0;
    int mx    = 0;
    int my    = 0;

    logic [7:0] img [H][W];
    int         acc [H][W];

    typedef struct {
        int            cyc;
        logic [DW-1:0] d;
        logic          fd;
    } win_t;

    win_t obs_q[$];
    win_t exp_q[$];

    window_buffer #(
        .OPE_SIZE  (N),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .reflesh   (reflesh),
        .in        (in),
        .d         (d),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every cycle showing a valid bit or frame_done.
    always @(negedge clk) begin
        logic va;
        logic vl;
        win_t w;
        va = 1'b0;
        vl = 1'b1;
        for (int k = 0; k < N * N; k++) begin
            va = va | d[9*k+8];
            vl = vl & d[9*k+8];
        end
        if (va != vl) vbad++;
        if (va || frame_done) begin
            w.cyc = cyc;
            w.d   = d;
            w.fd  = frame_done;
            obs_q.push_back(w);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one cycle and advance the reference model.
    task automatic send(input logic [7:0] v, input bit vld, input bit rf);
        win_t e;
        in      = {vld, v};
        reflesh = rf;
        @(posedge clk);
        #1;
        in      = 9'h0;
        reflesh = 1'b0;
        if (rf) begin
            mx = 0;
            my = 0;
            while (exp_q.size() > 0 && exp_q[$].cyc >= cyc)
                exp_q.delete(exp_q.size() - 1);
        end else if (vld) begin
            img[my][mx] = v;
            acc[my][mx] = cyc;
            if (mx >= N - 1 && my >= N - 1) begin
                e.cyc = cyc + 1;
                e.fd  = (mx == W - 1 && my == H - 1);
                e.d   = '0;
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        e.d[9*(i*N+j) +: 9] =
                            {1'b1, img[my-N+1+i][mx-N+1+j]};
                exp_q.push_back(e);
            end
            if (mx == W - 1) begin
                mx = 0;
                my = (my == H - 1) ? 0 : my + 1;
            end else begin
                mx++;
            end
        end
    endtask

    task automatic drive_frame(input int gap, input bit rnd);
        for (int yy = 0; yy < H; yy++) begin
            for (int xx = 0; xx < W; xx++) begin
                if (gap > 0) idle(int'($urandom_range(0, gap)));
                send(rnd ? 8'($urandom) : 8'(yy * 16 + xx), 1'b1, 1'b0);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in  = 9'h1ab;
        repeat (4) begin
            @(negedge clk);
            total++;
            if (d !== '0 || frame_done !== 1'b0) begin
                bad++;
                $display("FAIL reset_out d=%h fd=%b want d=0 fd=0",
                         d, frame_done);
            end
        end
        in  = 9'h0;
        rst = 1'b1;
        mx  = 0;
        my  = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_frame(input int gap, input bit rnd,
                              input string nm);
        int ob;
        int vb;
        int n;
        ob = obs_q.size();
        vb = vbad;
        exp_q.delete();
        drive_frame(gap, rnd);
        idle(4);
        n = obs_q.size() - ob;
        total++;
        if (n != 24 || exp_q.size() != 24) begin
            bad++;
            $display("FAIL %s_count got=%0d want=24 (model %0d)",
                     nm, n, exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < n; k++) begin
            total++;
            if (obs_q[ob+k].cyc !== exp_q[k].cyc ||
                obs_q[ob+k].d   !== exp_q[k].d   ||
                obs_q[ob+k].fd  !== exp_q[k].fd) begin
                bad++;
                $display("FAIL %s_win%0d got cyc=%0d d=%h fd=%b want cyc=%0d d=%h fd=%b",
                         nm, k, obs_q[ob+k].cyc, obs_q[ob+k].d,
                         obs_q[ob+k].fd, exp_q[k].cyc, exp_q[k].d,
                         exp_q[k].fd);
            end
        end
        if (!rnd && n >= 24) begin
            total++;
            if (obs_q[ob].d[8:0]   !== 9'h100 ||
                obs_q[ob].d[44:36] !== 9'h111 ||
                obs_q[ob].d[80:72] !== 9'h122) begin
                bad++;
                $display("FAIL %s_first got d=%h want t00=100 c=111 t22=122",
                         nm, obs_q[ob].d);
            end
            total++;
            if (obs_q[ob+23].d[44:36] !== 9'h146 ||
                obs_q[ob+23].fd !== 1'b1) begin
                bad++;
                $display("FAIL %s_last got c=%h fd=%b want c=146 fd=1",
                         nm, obs_q[ob+23].d[44:36], obs_q[ob+23].fd);
            end
        end
        total++;
        if (vbad != vb) begin
            bad++;
            $display("FAIL %s_vbits got=%0d want=0", nm, vbad - vb);
        end
    endtask

    task automatic test_row_wrap();
        int ob;
        ob = obs_q.size();
        exp_q.delete();
        drive_frame(0, 1'b0);
        idle(4);
        for (int xx = 0; xx < 3; xx++) begin
            int due;
            int hit;
            due = acc[3][xx] + 1;
            hit = -1;
            for (int k = ob; k < obs_q.size(); k++)
                if (obs_q[k].cyc == due) hit = k;
            total++;
            if (xx < 2) begin
                if (hit != -1) begin
                    bad++;
                    $display("FAIL row_wrap_x%0d got valid d=%h want none",
                             xx, obs_q[hit].d);
                end
            end else if (hit == -1) begin
                bad++;
                $display("FAIL row_wrap_x2 got none want c=121");
            end else if (obs_q[hit].d[8:0]   !== 9'h110 ||
                         obs_q[hit].d[44:36] !== 9'h121 ||
                         obs_q[hit].d[80:72] !== 9'h132) begin
                bad++;
                $display("FAIL row_wrap_x2 got d=%h want t00=110 c=121 t22=132",
                         obs_q[hit].d);
            end
        end
    endtask

    task automatic test_reflesh();
        int ob;
        int r;
        int n;
        ob = obs_q.size();
        exp_q.delete();
        for (int p = 0; p < 20; p++)
            send(8'((p / 8) * 16 + p % 8), 1'b1, 1'b0);
        send(8'h24, 1'b1, 1'b1);
        r = cyc;
        idle(3);
        n = 0;
        for (int k = ob; k < obs_q.size(); k++)
            if (obs_q[k].cyc >= r) n++;
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL reflesh_flight got=%0d want=0", n);
        end
        total++;
        if (obs_q.size() - ob != 1 || obs_q[ob].d[44:36] !== 9'h111) begin
            bad++;
            $display("FAIL reflesh_pre got n=%0d want n=1 c=111",
                     obs_q.size() - ob);
        end
        test_frame(2, 1'b0, "reflesh_restart");
    endtask

    task automatic test_back_to_back();
        int ob;
        int n;
        int f0;
        int f1;
        int nf;
        ob = obs_q.size();
        exp_q.delete();
        drive_frame(0, 1'b0);
        drive_frame(0, 1'b0);
        idle(4);
        n = obs_q.size() - ob;
        total++;
        if (n != 48 || exp_q.size() != 48) begin
            bad++;
            $display("FAIL b2b_count got=%0d want=48 (model %0d)",
                     n, exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < n; k++) begin
            total++;
            if (obs_q[ob+k].cyc !== exp_q[k].cyc ||
                obs_q[ob+k].d   !== exp_q[k].d   ||
                obs_q[ob+k].fd  !== exp_q[k].fd) begin
                bad++;
                $display("FAIL b2b_win%0d got cyc=%0d d=%h fd=%b want cyc=%0d d=%h fd=%b",
                         k, obs_q[ob+k].cyc, obs_q[ob+k].d,
                         obs_q[ob+k].fd, exp_q[k].cyc, exp_q[k].d,
                         exp_q[k].fd);
            end
        end
        nf = 0;
        f0 = 0;
        f1 = 0;
        for (int k = ob; k < obs_q.size(); k++) begin
            if (obs_q[k].fd) begin
                if (nf == 0) f0 = obs_q[k].cyc;
                else f1 = obs_q[k].cyc;
                nf++;
            end
        end
        total++;
        if (nf != 2 || f1 - f0 != 48) begin
            bad++;
            $display("FAIL b2b_fd got n=%0d gap=%0d want n=2 gap=48",
                     nf, f1 - f0);
        end
        if (n > 24) begin
            total++;
            if (obs_q[ob+24].d[44:36] !== 9'h111) begin
                bad++;
                $display("FAIL b2b_second_first got c=%h want c=111",
                         obs_q[ob+24].d[44:36]);
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_frame(0, 1'b0, "gapless");
        test_frame(3, 1'b0, "idle_gaps");
        test_frame(2, 1'b1, "rand_pix");
        test_row_wrap();
        test_reflesh();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
